// File: rtl/byte_serializer.sv
// byte_serializer: captures a 32-bit word presented as four byte lanes and
// emits it one byte per cycle over a valid/ready stream.
//
// Parameters:
//   MSB_FIRST  1: emit B1,B2,B3,B4   0: emit B4,B3,B2,B1
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-low reset
//   in_valid   upstream word presented on B1..B4
//   B1..B4     byte lanes, word bits [31:24],[23:16],[15:8],[7:0]
//   in_ready   word accepted this cycle when in_valid is also high
//   out_valid  out_data holds a valid byte
//   out_ready  downstream takes out_data this cycle
//   out_data   current byte (8'h00 when out_valid is low)
//   out_last   current byte is the 4th of its word
//   word_cnt   fully emitted words, modulo 256
module byte_serializer #(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] B1,
  input  logic [7:0] B2,
  input  logic [7:0] B3,
  input  logic [7:0] B4,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] word_cnt
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  cnt_q, cnt_d;

  logic       accept;
  logic       xfer;
  logic [1:0] lane;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // Ready on the last byte lets the next word load with no idle bubble.
    in_ready  = reset & ((state_q == StIdle) |
                         ((state_q == StSend) & (idx_q == 2'd3) & out_ready));
    out_valid = (state_q == StSend);
    out_last  = out_valid & (idx_q == 2'd3);
    accept    = in_valid & in_ready;
    xfer      = out_valid & out_ready;

    // Lane 0 is B1; LSB-first order walks the lanes backwards.
    lane = (MSB_FIRST != 0) ? idx_q : (2'd3 - idx_q);
    out_data = 8'h00;
    if (out_valid) begin
      case (lane)
        2'd0:    out_data = word_q[31:24];
        2'd1:    out_data = word_q[23:16];
        2'd2:    out_data = word_q[15:8];
        default: out_data = word_q[7:0];
      endcase
    end
    word_cnt = cnt_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSend;
          idx_d   = 2'd0;
          word_d  = {B1, B2, B3, B4};
        end
      end
      StSend: begin
        if (xfer) begin
          if (idx_q == 2'd3) begin
            cnt_d = cnt_q + 8'd1;
            idx_d = 2'd0;
            if (accept) begin
              word_d = {B1, B2, B3, B4};
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: drives both emit orders from one stimulus stream
// and checks every cycle against a byte-queue reference model.
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] B1, B2, B3, B4;
  logic       out_ready;

  logic       in_ready_m, out_valid_m, out_last_m;
  logic [7:0] out_data_m, word_cnt_m;
  logic       in_ready_l, out_valid_l, out_last_l;
  logic [7:0] out_data_l, word_cnt_l;

  always #5 clk = ~clk;

  byte_serializer #(.MSB_FIRST(1)) u_msb (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .B1        (B1),
    .B2        (B2),
    .B3        (B3),
    .B4        (B4),
    .in_ready  (in_ready_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .out_data  (out_data_m),
    .out_last  (out_last_m),
    .word_cnt  (word_cnt_m)
  );

  byte_serializer #(.MSB_FIRST(0)) u_lsb (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .B1        (B1),
    .B2        (B2),
    .B3        (B3),
    .B4        (B4),
    .in_ready  (in_ready_l),
    .out_valid (out_valid_l),
    .out_ready (out_ready),
    .out_data  (out_data_l),
    .out_last  (out_last_l),
    .word_cnt  (word_cnt_l)
  );

  int checks = 0;
  int errors = 0;

  // Model: bytes still owed downstream, in emit order, per instance.
  logic [7:0] qm[$];
  logic [7:0] ql[$];
  logic [7:0] exp_cnt = 8'd0;
  logic       armed = 1'b0;
  logic       took = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares at the falling edge, then advances the model to what the
  // next rising edge will do.
  always @(negedge clk) begin
    logic exp_v, exp_rdy;
    if (!reset) begin
      if (armed) begin
        chk("in_ready_rst_m", {7'd0, in_ready_m}, 8'd0);
        chk("in_ready_rst_l", {7'd0, in_ready_l}, 8'd0);
      end
      qm.delete();
      ql.delete();
      exp_cnt = 8'd0;
      took    = 1'b0;
      armed   = 1'b1;
    end else if (armed) begin
      exp_v   = (qm.size() != 0);
      exp_rdy = (qm.size() == 0) || ((qm.size() == 1) && out_ready);
      chk("out_valid_m", {7'd0, out_valid_m}, {7'd0, exp_v});
      chk("out_valid_l", {7'd0, out_valid_l}, {7'd0, exp_v});
      chk("out_last_m", {7'd0, out_last_m}, {7'd0, qm.size() == 1});
      chk("out_last_l", {7'd0, out_last_l}, {7'd0, ql.size() == 1});
      chk("out_data_m", out_data_m, exp_v ? qm[0] : 8'h00);
      chk("out_data_l", out_data_l, exp_v ? ql[0] : 8'h00);
      chk("word_cnt_m", word_cnt_m, exp_cnt);
      chk("word_cnt_l", word_cnt_l, exp_cnt);
      chk("in_ready_m", {7'd0, in_ready_m}, {7'd0, exp_rdy});
      chk("in_ready_l", {7'd0, in_ready_l}, {7'd0, exp_rdy});
      if (exp_v && out_ready) begin
        if (qm.size() == 1) exp_cnt = exp_cnt + 8'd1;
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      took = in_valid && exp_rdy;
      if (took) begin
        qm.push_back(B1); qm.push_back(B2); qm.push_back(B3); qm.push_back(B4);
        ql.push_back(B4); ql.push_back(B3); ql.push_back(B2); ql.push_back(B1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until the model says it was accepted.
  task automatic send(input logic [31:0] w);
    int n = 0;
    {B1, B2, B3, B4} = w;
    in_valid = 1'b1;
    forever begin
      step();
      if (took) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout word=%h actual=not_accepted required=accepted", w);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (qm.size() != 0) begin
      step();
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout actual=%0d bytes_left required=0", qm.size());
        break;
      end
    end
    step();
  endtask

  task automatic random_run(input int cycles, input bit with_reset);
    for (int i = 0; i < cycles; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      reset = !(with_reset && ($urandom_range(0, 63) == 0));
      if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        {B1, B2, B3, B4} = $urandom;
      end
      step();
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    {B1, B2, B3, B4} = 32'd0;
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();

    send(32'h000003E8);
    drain();

    send(32'h11223344);
    send(32'hAABBCCDD);
    drain();

    // Stall three cycles while the second byte is on the bus.
    send(32'hDEADBEEF);
    step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    drain();

    // Reset with the third byte pending.
    send(32'hCAFEF00D);
    repeat (2) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    send(32'h01020304);
    drain();

    // Long run without reset so word_cnt passes 255.
    random_run(2400, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    random_run(600, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
